axis_serializer: RTL

AXIS_SERIALIZER -- requirements
Module: axis_serializer

---
 rtl/axis_serializer_pkg.sv | 18 +
 rtl/axis_serializer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/axis_serializer_pkg.sv
// Shared helpers for the AXI-stream width converters.
// Only the index-sizing function is needed by the serializer.
package axis_serializer_pkg;

  // Ceiling log2, never below 1 so a 1-bit index always exists.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_serializer.sv
// Wide-to-narrow AXI-stream serializer: splits each up word into DATA_NB slices.
// Define AXIS_SERIALIZER_MSB_FIRST_EN to emit slices MSB-first (default LSB-first).
module axis_serializer
  import axis_serializer_pkg::*;
#(
  parameter int DATA_NB    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          up_ready,
  input  logic                          up_valid,
  input  logic [DATA_WIDTH*DATA_NB-1:0] up_data,
  input  logic                          up_last,
  input  logic                          down_ready,
  output logic                          down_valid,
  output logic [DATA_WIDTH-1:0]         down_data,
  output logic                          down_last
);

  localparam int WORD_W = DATA_WIDTH * DATA_NB;
  localparam int IDX_W  = clog2(DATA_NB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_NB - 1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic                    last_q, last_d;
  logic [DATA_WIDTH-1:0]   down_data_q, down_data_d;
  logic                    down_last_q, down_last_d;
  logic                    down_valid_q;

  logic                    up_hs;
  logic                    down_hs;
  logic                    idx_is_last;
  logic [IDX_W-1:0]        idx_nxt;

  function automatic logic [DATA_WIDTH-1:0] slice_of(input logic [WORD_W-1:0] w,
                                                      input logic [IDX_W-1:0]  k);
    int pos;
`ifdef AXIS_SERIALIZER_MSB_FIRST_EN
    pos = DATA_NB - 1 - int'(k);
`else
    pos = int'(k);
`endif
    return w[pos*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign idx_is_last = (idx_q == IDX_LAST);
  assign idx_nxt     = idx_q + 1'b1;

  // Ready is combinational so the final slice and the next word overlap without a bubble.
  assign up_ready = !rst && ((state_q == EMPTY) || (idx_is_last && down_ready));
  assign up_hs    = up_valid && up_ready;
  assign down_hs  = down_valid_q && down_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    last_d      = last_q;
    down_data_d = down_data_q;
    down_last_d = down_last_q;
    case (state_q)
      EMPTY: begin
        if (up_hs) begin
          state_d     = SHIFT;
          idx_d       = '0;
          word_d      = up_data;
          last_d      = up_last;
          down_data_d = slice_of(up_data, '0);
          down_last_d = 1'b0;
        end
      end
      SHIFT: begin
        if (down_hs) begin
          if (!idx_is_last) begin
            idx_d       = idx_nxt;
            down_data_d = slice_of(word_q, idx_nxt);
            down_last_d = last_q && (idx_nxt == IDX_LAST);
          end else if (up_hs) begin
            idx_d       = '0;
            word_d      = up_data;
            last_d      = up_last;
            down_data_d = slice_of(up_data, '0);
            down_last_d = 1'b0;
          end else begin
            state_d     = EMPTY;
            down_last_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = EMPTY;
        down_last_d = 1'b0;
      end
    endcase
  end

  // Control registers: reset discards any partially emitted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      idx_q        <= '0;
      last_q       <= 1'b0;
      down_last_q  <= 1'b0;
      down_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      down_last_q  <= down_last_d;
      down_valid_q <= (state_d == SHIFT);
    end
  end

  // Data registers carry no reset; they are qualified by down_valid.
  always_ff @(posedge clk) begin
    word_q      <= word_d;
    down_data_q <= down_data_d;
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_last  = down_last_q;

endmodule
